wots_chain_engine: RTL and testbench

- Parametrised WOTS+ chain engine for SPHINCS+ signing and verification datapaths. It runs all LEN chains in one of three modes:
  - SIGN: secret key generation plus chain(0, d_i).
  - PKGEN: chain(0, W-1).
  - PK_FROM_SIG: chain(d_i, W-1-d_i) on supplied signature elements.
- It sits between the hypertree controller and the shared SHA-256 hash core.
- It drives one hash request per PRF or F call and streams per-chain results out under ready/valid backpressure.

---
 rtl/wots_pkg.sv | 48 ++++
 rtl/wots_chain_engine_if.sv | 42 ++++
 rtl/wots_base_w.sv | 51 +++++
 rtl/wots_chain_engine.sv | 172 +++++++++++++++++
 tb/tb_wots_chain_engine.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wots_pkg.sv
// Shared definitions for the WOTS+ chain engine: mode encodings, address
// field layout, parameter-derived sizes and the controller state encoding.
package wots_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN        = 2'd0,
        MODE_PKGEN       = 2'd1,
        MODE_PK_FROM_SIG = 2'd2,
        MODE_RSVD        = 2'd3
    } wots_mode_t;

    localparam int CHAIN_LSB = 112;
    localparam int HASH_LSB  = 80;

    typedef enum logic [2:0] {
        IDLE,
        CSUM,
        LOAD,
        SK_WAIT,
        STEP_REQ,
        STEP_WAIT,
        OUT
    } wots_state_t;

    function automatic int calc_len1(input int n_bits, input int log_w);
        return n_bits / log_w;
    endfunction

    function automatic int calc_csum_bits(input int len2, input int log_w);
        return 8 * ((len2 * log_w + 7) / 8);
    endfunction

    // Left-aligns the checksum so its digits start at the top of the byte-padded field
    function automatic int calc_csum_shift(input int len2, input int log_w);
        return (8 - (len2 * log_w) % 8) % 8;
    endfunction

    function automatic logic [255:0] set_chain_addr(input logic [255:0] base,
                                                    input logic [7:0]   chain,
                                                    input logic [7:0]   hidx);
        logic [255:0] a;
        a = base;
        a[CHAIN_LSB +: 8] = chain;
        a[HASH_LSB +: 8]  = hidx;
        return a;
    endfunction

endpackage

// File: rtl/wots_chain_engine_if.sv
// Control, signature, hash-core and result streams of the WOTS+ chain engine.
// The engine sits on the slave side; controller and hash core on the master side.
interface wots_chain_engine_if #(parameter int N_BITS = 256);

    logic              start;
    logic [1:0]        mode;
    logic [N_BITS-1:0] msg;
    logic [255:0]      wots_addr;
    logic [N_BITS-1:0] sk_seed;
    logic [N_BITS-1:0] pub_seed;
    logic [N_BITS-1:0] sig_in;
    logic              sig_in_vld;
    logic              sig_in_rdy;
    logic              hash_req;
    logic              hash_op;
    logic [N_BITS-1:0] hash_key;
    logic [255:0]      hash_addr;
    logic [N_BITS-1:0] hash_in;
    logic              hash_done;
    logic [N_BITS-1:0] hash_dout;
    logic [N_BITS-1:0] dout;
    logic [7:0]        dout_idx;
    logic              dout_vld;
    logic              dout_rdy;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mode, msg, wots_addr, sk_seed, pub_seed,
               sig_in, sig_in_vld, hash_done, hash_dout, dout_rdy,
        output sig_in_rdy, hash_req, hash_op, hash_key, hash_addr, hash_in,
               dout, dout_idx, dout_vld, busy, done
    );

    modport master (
        output start, mode, msg, wots_addr, sk_seed, pub_seed,
               sig_in, sig_in_vld, hash_done, hash_dout, dout_rdy,
        input  sig_in_rdy, hash_req, hash_op, hash_key, hash_addr, hash_in,
               dout, dout_idx, dout_vld, busy, done
    );

endinterface

// File: rtl/wots_base_w.sv
// Base-W digit source: message digits come straight from msg, checksum digits
// from a checksum accumulated one message digit per cycle.
module wots_base_w
    import wots_pkg::*;
#(
    parameter int N_BITS = 256,
    parameter int LOG_W  = 4,
    parameter int LEN2   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] msg,
    input  logic              acc_clr,
    input  logic              acc_en,
    input  logic [7:0]        idx,
    output logic [LOG_W-1:0]  digit
);

    localparam int W          = 1 << LOG_W;
    localparam int LEN1       = calc_len1(N_BITS, LOG_W);
    localparam int CSUM_BITS  = calc_csum_bits(LEN2, LOG_W);
    localparam int CSUM_SHIFT = calc_csum_shift(LEN2, LOG_W);

    logic [CSUM_BITS-1:0] csum;
    logic [CSUM_BITS-1:0] csum_vec;
    logic [7:0]           csum_j;
    logic [15:0]          msg_shamt;
    logic [15:0]          csum_shamt;
    logic [LOG_W-1:0]     msg_digit;
    logic [LOG_W-1:0]     csum_digit;

    // Out-of-range indices wrap the shift amounts; the mux below never selects those results
    assign msg_shamt  = 16'(N_BITS) - (16'(idx) + 16'd1) * 16'(LOG_W);
    assign csum_j     = idx - 8'(LEN1);
    assign csum_shamt = 16'(CSUM_BITS) - (16'(csum_j) + 16'd1) * 16'(LOG_W);
    assign csum_vec   = csum << CSUM_SHIFT;
    assign msg_digit  = LOG_W'(msg >> msg_shamt);
    assign csum_digit = LOG_W'(csum_vec >> csum_shamt);
    assign digit      = (idx < 8'(LEN1)) ? msg_digit : csum_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (acc_clr) begin
            csum <= '0;
        end else if (acc_en) begin
            csum <= csum + (CSUM_BITS'(W - 1) - CSUM_BITS'(msg_digit));
        end
    end

endmodule

// File: rtl/wots_chain_engine.sv
// WOTS+ chain engine: walks all LEN chains for SIGN, PKGEN or PK_FROM_SIG,
// issuing one hash call per PRF/F step and streaming each chain result out.
module wots_chain_engine
    import wots_pkg::*;
#(
    parameter int LOG_W  = 4,
    parameter int N_BITS = 256,
    parameter int LEN2   = 3
) (
    input logic                 clk,
    input logic                 rst,
    wots_chain_engine_if.slave  bus
);

    localparam int W    = 1 << LOG_W;
    localparam int LEN1 = calc_len1(N_BITS, LOG_W);
    localparam int LEN  = LEN1 + LEN2;

    wots_state_t       state_q, state_d;
    wots_mode_t        mode_q;
    logic [N_BITS-1:0] msg_q;
    logic [255:0]      addr_q;
    logic [7:0]        chain_idx;
    logic [7:0]        steps_left;
    logic [7:0]        hash_idx;
    logic [7:0]        start_s;
    logic [7:0]        steps;
    logic [N_BITS-1:0] value;
    logic [LOG_W-1:0]  digit;
    logic              accept_start, csum_last, last_chain, hash_take;
    logic              issue_prf, issue_f, sig_take, out_take;
    logic              hash_req_q, hash_op_q, done_q;
    logic [N_BITS-1:0] hash_key_q, hash_in_q;
    logic [255:0]      hash_addr_q;

    wots_base_w #(.N_BITS(N_BITS), .LOG_W(LOG_W), .LEN2(LEN2)) u_base_w (
        .clk     (clk),
        .rst     (rst),
        .msg     (msg_q),
        .acc_clr (accept_start),
        .acc_en  (state_q == CSUM),
        .idx     (chain_idx),
        .digit   (digit)
    );

    assign accept_start = (state_q == IDLE) && bus.start;
    assign csum_last    = chain_idx == 8'(LEN1 - 1);
    assign last_chain   = chain_idx == 8'(LEN - 1);
    assign hash_take    = ((state_q == SK_WAIT) || (state_q == STEP_WAIT)) && bus.hash_done;

    always_comb begin
        start_s = 8'd0;
        steps   = 8'(W - 1);
        case (mode_q)
            MODE_SIGN:        steps = 8'(digit);
            MODE_PK_FROM_SIG: begin
                start_s = 8'(digit);
                steps   = 8'(W - 1) - 8'(digit);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        issue_prf = 1'b0;
        issue_f   = 1'b0;
        sig_take  = 1'b0;
        out_take  = 1'b0;
        case (state_q)
            IDLE:      if (bus.start) state_d = CSUM;
            CSUM:      if (csum_last) state_d = LOAD;
            LOAD: begin
                if (mode_q == MODE_PK_FROM_SIG) begin
                    if (bus.sig_in_vld) begin
                        sig_take = 1'b1;
                        state_d  = STEP_REQ;
                    end
                end else begin
                    issue_prf = 1'b1;
                    state_d   = SK_WAIT;
                end
            end
            SK_WAIT:   if (bus.hash_done) state_d = STEP_REQ;
            STEP_REQ: begin
                if (steps_left == 8'd0) begin
                    state_d = OUT;
                end else begin
                    issue_f = 1'b1;
                    state_d = STEP_WAIT;
                end
            end
            STEP_WAIT: if (bus.hash_done) state_d = STEP_REQ;
            OUT: begin
                if (bus.dout_rdy) begin
                    out_take = 1'b1;
                    state_d  = last_chain ? IDLE : LOAD;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Hash request fields are only rewritten at issue, so they hold until hash_done
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_SIGN;
            msg_q       <= '0;
            addr_q      <= '0;
            chain_idx   <= '0;
            steps_left  <= '0;
            hash_idx    <= '0;
            value       <= '0;
            hash_req_q  <= 1'b0;
            hash_op_q   <= 1'b0;
            hash_key_q  <= '0;
            hash_addr_q <= '0;
            hash_in_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            hash_req_q <= issue_prf || issue_f;
            done_q     <= out_take && last_chain;
            if (accept_start) begin
                mode_q    <= (bus.mode == MODE_RSVD) ? MODE_PKGEN : wots_mode_t'(bus.mode);
                msg_q     <= bus.msg;
                addr_q    <= bus.wots_addr;
                chain_idx <= '0;
            end
            if (state_q == CSUM) chain_idx <= csum_last ? 8'd0 : chain_idx + 8'd1;
            if (state_q == LOAD) begin
                steps_left <= steps;
                hash_idx   <= start_s;
            end
            if (sig_take)  value <= bus.sig_in;
            if (hash_take) value <= bus.hash_dout;
            if ((state_q == STEP_WAIT) && bus.hash_done) begin
                steps_left <= steps_left - 8'd1;
                hash_idx   <= hash_idx + 8'd1;
            end
            if (issue_prf) begin
                hash_op_q   <= 1'b0;
                hash_key_q  <= bus.sk_seed;
                hash_addr_q <= set_chain_addr(addr_q, chain_idx, 8'd0);
            end
            if (issue_f) begin
                hash_op_q   <= 1'b1;
                hash_key_q  <= bus.pub_seed;
                hash_addr_q <= set_chain_addr(addr_q, chain_idx, hash_idx);
                hash_in_q   <= value;
            end
            if (out_take && !last_chain) chain_idx <= chain_idx + 8'd1;
        end
    end

    assign bus.sig_in_rdy = (state_q == LOAD) && (mode_q == MODE_PK_FROM_SIG);
    assign bus.hash_req   = hash_req_q;
    assign bus.hash_op    = hash_op_q;
    assign bus.hash_key   = hash_key_q;
    assign bus.hash_addr  = hash_addr_q;
    assign bus.hash_in    = hash_in_q;
    assign bus.dout       = value;
    assign bus.dout_idx   = chain_idx;
    assign bus.dout_vld   = state_q == OUT;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_wots_chain_engine.sv
// Randomized bench for wots_chain_engine: a chain-level reference model predicts
// every hash request and chain result; a counter-tagged hash core answers after 5 cycles.
module tb_wots_chain_engine;

    localparam int LOG_W      = 4;
    localparam int N_BITS     = 256;
    localparam int LEN2       = 3;
    localparam int W          = 1 << LOG_W;
    localparam int LEN1       = N_BITS / LOG_W;
    localparam int LEN        = LEN1 + LEN2;
    localparam int HASH_LAT   = 5;
    localparam int RUN_BUDGET = 20000;

    typedef struct {
        logic         op;
        int           chain;
        int           hidx;
        logic [255:0] hin;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wots_chain_engine_if #(.N_BITS(N_BITS)) bus();

    wots_chain_engine #(.LOG_W(LOG_W), .N_BITS(N_BITS), .LEN2(LEN2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t         exp_q[$];
    logic [255:0] exp_dout [LEN];
    logic [255:0] sigs [LEN];
    logic [255:0] salt;
    logic [255:0] run_addr;
    int           total = 0;
    int           bad = 0;
    int           run_req = 0;
    int           exp_reqs = 0;
    int           pend_cnt = 0;
    int           pend_k = 0;
    int           out_ptr = 0;
    int           sig_ptr = 0;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] randWord();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] tagOf(input int k);
        return salt ^ 256'(k);
    endfunction

    // Digits as base-16 numbers: message nibbles MSB first, then the checksum times 16
    function automatic int digitOf(input logic [255:0] m, input int i);
        logic [255:0] t;
        int           csum;
        int           cv;
        if (i < LEN1) begin
            t = m >> (N_BITS - (i + 1) * LOG_W);
            return int'(t[3:0]);
        end
        csum = 0;
        for (int k = 0; k < LEN1; k++) begin
            t = m >> (N_BITS - (k + 1) * LOG_W);
            csum += W - 1 - int'(t[3:0]);
        end
        cv = csum * 16;
        return (cv >> (12 - 4 * (i - LEN1))) % 16;
    endfunction

    function automatic logic [255:0] expAddr(input logic [255:0] base, input int chain, input int hidx);
        logic [255:0] mask;
        mask = (256'hFF << 112) | (256'hFF << 80);
        return (base & ~mask) | (256'(chain) << 112) | (256'(hidx) << 80);
    endfunction

    task automatic buildModel(input logic [1:0] m, input logic [255:0] msg);
        int           k;
        int           d, s, n;
        bit           prf;
        logic [255:0] v;
        req_t         r;
        k = 0;
        exp_q.delete();
        for (int i = 0; i < LEN; i++) begin
            d = digitOf(msg, i);
            if (m == 2'd2)      begin s = d; n = W - 1 - d; prf = 0; end
            else if (m == 2'd0) begin s = 0; n = d;         prf = 1; end
            else                begin s = 0; n = W - 1;     prf = 1; end
            if (prf) begin
                r.op = 1'b0; r.chain = i; r.hidx = 0; r.hin = '0;
                exp_q.push_back(r);
                v = tagOf(k);
                k++;
            end else begin
                v = sigs[i];
            end
            for (int t = 0; t < n; t++) begin
                r.op = 1'b1; r.chain = i; r.hidx = s + t; r.hin = v;
                exp_q.push_back(r);
                v = tagOf(k);
                k++;
            end
            exp_dout[i] = v;
        end
        exp_reqs = k;
    endtask

    // Hash core model plus request checking, advanced once per falling edge
    task automatic serviceHash();
        req_t r;
        if (bus.hash_done) bus.hash_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.hash_done = 1'b1;
                bus.hash_dout = tagOf(pend_k);
            end
        end
        if (bus.hash_req === 1'b1) begin
            checkOutput("req_expected", 256'(exp_q.size() > 0), 256'(1));
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                checkOutput("req_op", 256'(bus.hash_op), 256'(r.op));
                checkOutput("req_addr", bus.hash_addr, expAddr(run_addr, r.chain, r.hidx));
                checkOutput("req_key", bus.hash_key, r.op ? bus.pub_seed : bus.sk_seed);
                if (r.op) checkOutput("req_hash_in", bus.hash_in, r.hin);
            end
            pend_k   = run_req;
            run_req++;
            pend_cnt = HASH_LAT;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        serviceHash();
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [255:0] msg,
                                 input int bp_idx, input int abort_at);
        int           cycles;
        int           bp_cnt;
        bit           finished;
        bit           aborted;
        logic [255:0] snap_d;
        logic [7:0]   snap_i;
        cycles = 0; bp_cnt = 0; finished = 0; aborted = 0;
        snap_d = '0; snap_i = '0;
        for (int i = 0; i < LEN; i++) sigs[i] = randWord();
        run_addr = randWord();
        buildModel((m == 2'd3) ? 2'd1 : m, msg);
        run_req = 0; out_ptr = 0; sig_ptr = 0;

        tick();
        bus.mode      = m;
        bus.msg       = msg;
        bus.wots_addr = run_addr;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.msg       = randWord();
        bus.wots_addr = randWord();
        bus.mode      = 2'($urandom_range(0, 3));
        checkOutput("busy_after_start", 256'(bus.busy), 256'(1));

        while (!finished && !aborted && cycles < RUN_BUDGET) begin
            tick();
            cycles++;
            if (abort_at > 0 && run_req == abort_at) begin
                rst = 1'b1;
                tick();
                checkOutput("abort_busy", 256'(bus.busy), 256'(0));
                checkOutput("abort_dout_vld", 256'(bus.dout_vld), 256'(0));
                checkOutput("abort_hash_req", 256'(bus.hash_req), 256'(0));
                rst = 1'b0;
                for (int c = 0; c < 12; c++) begin
                    tick();
                    checkOutput("idle_busy", 256'(bus.busy), 256'(0));
                    checkOutput("idle_no_req", 256'(bus.hash_req), 256'(0));
                    checkOutput("idle_no_done", 256'(bus.done), 256'(0));
                end
                aborted = 1;
            end else begin
                bus.sig_in     = sigs[(sig_ptr < LEN) ? sig_ptr : 0];
                bus.sig_in_vld = 1'b1;
                if (bus.sig_in_rdy) sig_ptr++;

                if ((bp_cnt > 0 && bp_cnt < 10) || (bp_cnt == 0 && bus.dout_vld && out_ptr == bp_idx)) begin
                    if (bp_cnt == 0) begin
                        snap_d = bus.dout;
                        snap_i = bus.dout_idx;
                    end else begin
                        checkOutput("bp_dout_stable", bus.dout, snap_d);
                        checkOutput("bp_idx_stable", 256'(bus.dout_idx), 256'(snap_i));
                        checkOutput("bp_vld_held", 256'(bus.dout_vld), 256'(1));
                    end
                    checkOutput("bp_no_hash_req", 256'(bus.hash_req), 256'(0));
                    bus.dout_rdy = 1'b0;
                    bp_cnt++;
                end else begin
                    bus.dout_rdy = 1'b1;
                end

                if (bus.dout_vld && bus.dout_rdy) begin
                    if (out_ptr < LEN) begin
                        checkOutput("dout_idx", 256'(bus.dout_idx), 256'(out_ptr));
                        checkOutput("dout_val", bus.dout, exp_dout[out_ptr]);
                    end
                    out_ptr++;
                end

                if (bus.done) begin
                    finished = 1;
                    checkOutput("done_after_outputs", 256'(out_ptr), 256'(LEN));
                    checkOutput("hash_req_total", 256'(run_req), 256'(exp_reqs));
                    checkOutput("busy_low_at_done", 256'(bus.busy), 256'(0));
                end
            end
        end
        checkOutput("run_finished", 256'(finished || aborted), 256'(1));
        bus.sig_in_vld = 1'b0;
        bus.dout_rdy   = 1'b1;
    endtask

    initial begin
        logic [255:0] m;
        salt           = randWord();
        bus.start      = 1'b0;
        bus.mode       = 2'd0;
        bus.msg        = '0;
        bus.wots_addr  = '0;
        bus.sk_seed    = randWord();
        bus.pub_seed   = randWord();
        bus.sig_in     = '0;
        bus.sig_in_vld = 1'b0;
        bus.hash_done  = 1'b0;
        bus.hash_dout  = '0;
        bus.dout_rdy   = 1'b1;

        rst = 1'b1;
        repeat (3) tick();
        checkOutput("rst_hash_req", 256'(bus.hash_req), 256'(0));
        checkOutput("rst_busy", 256'(bus.busy), 256'(0));
        checkOutput("rst_done", 256'(bus.done), 256'(0));
        checkOutput("rst_dout_vld", 256'(bus.dout_vld), 256'(0));
        checkOutput("rst_sig_in_rdy", 256'(bus.sig_in_rdy), 256'(0));
        checkOutput("rst_dout", bus.dout, 256'(0));
        checkOutput("rst_hash_addr", bus.hash_addr, 256'(0));
        checkOutput("rst_hash_key", bus.hash_key, 256'(0));
        rst = 1'b0;
        repeat (2) tick();

        applyStimulus(2'd0, '0, -1, 0);
        checkOutput("sign_zero_req_count", 256'(run_req), 256'(82));

        m = randWord();
        applyStimulus(2'd1, m, 3, 0);
        checkOutput("pkgen_req_count", 256'(run_req), 256'(1072));

        applyStimulus(2'd2, '1, -1, 0);
        checkOutput("pkfs_allf_req_count", 256'(run_req), 256'(45));

        m = randWord();
        m[235:232] = 4'd7;
        applyStimulus(2'd0, m, -1, 0);

        applyStimulus(2'd2, randWord(), -1, 0);

        applyStimulus(2'd1, randWord(), -1, 20);
        applyStimulus(2'd0, randWord(), 5, 0);

        applyStimulus(2'd3, randWord(), -1, 0);
        checkOutput("mode3_req_count", 256'(run_req), 256'(1072));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
